// File: rtl/pipelined_alu_unit_if.sv
// Issue/result bundle for pipelined_alu_unit: operation offer, result hand-off
// and write strobes.
interface pipelined_alu_unit_if #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int TAG_W           = 6,
  parameter int STAGES          = 2,
  parameter int ALU_OP_WIDTH    = 4,
  parameter int SRC_A_SEL_WIDTH = 2,
  parameter int SRC_B_SEL_WIDTH = 2
);
  logic                          issue_i;
  logic                          ready_o;
  logic [ALU_OP_WIDTH-1:0]       alu_op_i;
  logic [DATA_W-1:0]             src1_i;
  logic [DATA_W-1:0]             src2_i;
  logic [ADDR_W-1:0]             pc_i;
  logic [DATA_W-1:0]             imm_i;
  logic [SRC_A_SEL_WIDTH-1:0]    src_a_select_i;
  logic [SRC_B_SEL_WIDTH-1:0]    src_b_select_i;
  logic                          if_write_rrf_i;
  logic [TAG_W-1:0]              tag_i;
  logic                          flush_i;
  logic                          accept_i;
  logic                          valid_o;
  logic [DATA_W-1:0]             result_o;
  logic [TAG_W-1:0]              tag_o;
  logic                          rob_we_o;
  logic                          rrf_we_o;
  logic [$clog2(STAGES+1)-1:0]   inflight_o;

  modport slave (
    input  issue_i, alu_op_i, src1_i, src2_i, pc_i, imm_i,
           src_a_select_i, src_b_select_i, if_write_rrf_i, tag_i,
           flush_i, accept_i,
    output ready_o, valid_o, result_o, tag_o, rob_we_o, rrf_we_o, inflight_o
  );

  modport master (
    output issue_i, alu_op_i, src1_i, src2_i, pc_i, imm_i,
           src_a_select_i, src_b_select_i, if_write_rrf_i, tag_i,
           flush_i, accept_i,
    input  ready_o, valid_o, result_o, tag_o, rob_we_o, rrf_we_o, inflight_o
  );
endinterface

// File: rtl/pipelined_alu_unit.sv
// Integer ALU computed at issue, then carried through STAGES lock-step register
// stages; the whole pipe stalls while the head result is not accepted.
module pipelined_alu_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 6,
  parameter int STAGES = 2
) (
  input logic               clk_i,
  input logic               reset_n_i,
  pipelined_alu_unit_if.slave bus
);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(STAGES + 1);
  localparam int LAST  = STAGES - 1;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_OR   = 4'd7,
    ALU_AND  = 4'd8,
    ALU_SUB  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_e;

  logic [DATA_W-1:0] opnd_a, opnd_b, alu_res;
  logic [SH_W-1:0]   shamt;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] wr_q;
  logic [DATA_W-1:0] res_q [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic              stall;
  logic [CNT_W-1:0]  count;

  always_comb begin
    opnd_a = '0;
    case (bus.src_a_select_i)
      SRC_A_RS1:  opnd_a = bus.src1_i;
      SRC_A_PC:   opnd_a = DATA_W'(bus.pc_i);
      SRC_A_ZERO: opnd_a = '0;
      default:    opnd_a = '0;
    endcase
    opnd_b = '0;
    case (bus.src_b_select_i)
      SRC_B_RS2:  opnd_b = bus.src2_i;
      SRC_B_IMM:  opnd_b = bus.imm_i;
      SRC_B_FOUR: opnd_b = DATA_W'(4);
      default:    opnd_b = '0;
    endcase
  end

  always_comb begin
    shamt   = opnd_b[SH_W-1:0];
    alu_res = '0;
    case (bus.alu_op_i)
      ALU_ADD:  alu_res = opnd_a + opnd_b;
      ALU_SUB:  alu_res = opnd_a - opnd_b;
      ALU_SLL:  alu_res = opnd_a << shamt;
      ALU_SLT:  alu_res = DATA_W'($signed(opnd_a) < $signed(opnd_b));
      ALU_SLTU: alu_res = DATA_W'(opnd_a < opnd_b);
      ALU_XOR:  alu_res = opnd_a ^ opnd_b;
      ALU_SRL:  alu_res = opnd_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(opnd_a) >>> shamt);
      ALU_OR:   alu_res = opnd_a | opnd_b;
      ALU_AND:  alu_res = opnd_a & opnd_b;
      default:  alu_res = '0;
    endcase
  end

  assign stall = valid_q[LAST] && !bus.accept_i;

  // Flush outranks stall and accept; stages advance together so bubbles stay put.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      wr_q    <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (bus.flush_i) begin
      valid_q <= '0;
    end else if (!stall) begin
      valid_q[0] <= bus.issue_i;
      wr_q[0]    <= bus.if_write_rrf_i;
      res_q[0]   <= alu_res;
      tag_q[0]   <= bus.tag_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        wr_q[i]    <= wr_q[i-1];
        res_q[i]   <= res_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < STAGES; i++)
      count = count + CNT_W'(valid_q[i]);
  end

  assign bus.ready_o    = !stall;
  assign bus.valid_o    = valid_q[LAST];
  assign bus.result_o   = res_q[LAST];
  assign bus.tag_o      = tag_q[LAST];
  assign bus.rob_we_o   = valid_q[LAST] && bus.accept_i;
  assign bus.rrf_we_o   = valid_q[LAST] && bus.accept_i && wr_q[LAST];
  assign bus.inflight_o = count;
endmodule
